// File: rtl/mc10_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc10_arb_pkg : shared types and defaults for the MC-10 VRAM arbiter|
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package mc10_arb_pkg;
   localparam int ARB_AW           = 12;
   localparam int ARB_DW           = 8;
   localparam int ARB_CPU_MAX_WAIT = 3;
   localparam int STALL_W          = 16;
   localparam int OVR_W            = 8;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_VDG  = 2'd2
   } grant_t;
endpackage
`default_nettype wire

// File: rtl/mc10_vram_arbiter_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc10_vdg_fetch_slot : one-entry pending register for VDG fetches  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module mc10_vdg_fetch_slot
   import mc10_arb_pkg::*;
#(
   parameter int AW = ARB_AW
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          strobe,
   input  logic [AW-1:0] addr,
   input  logic          take,
   output logic          pending,
   output logic [AW-1:0] addr_q,
   output logic          overrun
);

   // A strobe always wins over a take: the newest address is what the VDG wants.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pending <= 1'b0;
         addr_q  <= '0;
      end else if (strobe) begin
         pending <= 1'b1;
         addr_q  <= addr;
      end else if (take) begin
         pending <= 1'b0;
      end
   end

   assign overrun = strobe & pending & ~take;

endmodule
`default_nettype wire

// File: rtl/mc10_vram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc10_vram_arbiter : CPU / VDG scheduler for the shared MC-10 RAM  |
// | Optional statistics counters: define MC10_ARB_STATS_EN            |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module mc10_vram_arbiter
   import mc10_arb_pkg::*;
#(
   parameter int AW           = ARB_AW,
   parameter int DW           = ARB_DW,
   parameter int CPU_MAX_WAIT = ARB_CPU_MAX_WAIT
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [AW-1:0]      cpu_addr,
   input  logic [DW-1:0]      cpu_wdata,
   output logic [DW-1:0]      cpu_rdata,
   output logic               cpu_ack,
   output logic               cpu_wait,
   input  logic               vdg_strobe,
   input  logic [AW-1:0]      vdg_addr,
   output logic [DW-1:0]      vdg_data,
   output logic               vdg_valid,
   output logic               vdg_overrun,
   output logic [AW-1:0]      ram_addr,
   output logic               ram_we,
   output logic [DW-1:0]      ram_wdata,
   input  logic [DW-1:0]      ram_rdata,
   output logic [STALL_W-1:0] stat_cpu_stall,
   output logic [OVR_W-1:0]   stat_vdg_ovr
);

   localparam int              WCW        = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
   localparam logic [WCW-1:0]  WAIT_LIMIT = WCW'(CPU_MAX_WAIT);

   grant_t         grant;
   grant_t         grant_q;
   logic [WCW-1:0] wait_cnt;
   logic [WCW-1:0] wait_nxt;
   logic           cpu_elig;
   logic           slot_pending;
   logic [AW-1:0]  slot_addr;
   logic           slot_overrun;
   logic [AW-1:0]  last_addr;
   logic           ack_is_write;
   logic           prev_wr;
   logic [AW-1:0]  prev_addr;
   logic [DW-1:0]  prev_data;
   logic           fwd_hit;
   logic [DW-1:0]  fwd_data;
   logic [DW-1:0]  rd_word;
   logic           overrun_q;

   mc10_vdg_fetch_slot #(.AW(AW)) u_slot (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .strobe  (vdg_strobe),
      .addr    (vdg_addr),
      .take    (grant == GNT_VDG),
      .pending (slot_pending),
      .addr_q  (slot_addr),
      .overrun (slot_overrun)
   );

   // The held request is ineligible during its own ack cycle, otherwise it would be granted twice.
   assign cpu_elig = cpu_req & ~cpu_ack;

   always_comb begin
      grant    = GNT_NONE;
      wait_nxt = wait_cnt;
      if (!reset_n) begin
         grant = GNT_NONE;
      end else if (cpu_elig && slot_pending) begin
         if (wait_cnt < WAIT_LIMIT) begin
            grant    = GNT_VDG;
            wait_nxt = wait_cnt + 1'b1;
         end else begin
            grant    = GNT_CPU;
            wait_nxt = '0;
         end
      end else if (cpu_elig) begin
         grant    = GNT_CPU;
         wait_nxt = '0;
      end else if (slot_pending) begin
         grant = GNT_VDG;
      end
      if (!cpu_req) begin
         wait_nxt = '0;
      end
   end

   always_comb begin
      ram_addr  = last_addr;
      ram_we    = 1'b0;
      ram_wdata = '0;
      case (grant)
         GNT_CPU: begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
         end
         GNT_VDG: ram_addr = slot_addr;
         default: ram_addr = last_addr;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         grant_q      <= GNT_NONE;
         wait_cnt     <= '0;
         last_addr    <= '0;
         ack_is_write <= 1'b0;
         prev_wr      <= 1'b0;
         prev_addr    <= '0;
         prev_data    <= '0;
         fwd_hit      <= 1'b0;
         fwd_data     <= '0;
         overrun_q    <= 1'b0;
      end else begin
         grant_q      <= grant;
         wait_cnt     <= wait_nxt;
         last_addr    <= ram_addr;
         ack_is_write <= (grant == GNT_CPU) & cpu_we;
         prev_wr      <= ram_we;
         prev_addr    <= ram_addr;
         prev_data    <= ram_wdata;
         // A read issued right behind a write to the same byte returns the written value.
         fwd_hit      <= (grant != GNT_NONE) & ~ram_we & prev_wr & (prev_addr == ram_addr);
         fwd_data     <= prev_data;
         overrun_q    <= overrun_q | slot_overrun;
      end
   end

   assign rd_word     = fwd_hit ? fwd_data : ram_rdata;
   assign cpu_ack     = (grant_q == GNT_CPU);
   assign vdg_valid   = (grant_q == GNT_VDG);
   assign cpu_rdata   = (cpu_ack && !ack_is_write) ? rd_word : '0;
   assign vdg_data    = vdg_valid ? rd_word : '0;
   assign vdg_overrun = overrun_q;
   assign cpu_wait    = reset_n & cpu_req & (grant != GNT_CPU) & ~cpu_ack;

`ifdef MC10_ARB_STATS_EN
   logic [STALL_W-1:0] stall_cnt;
   logic [OVR_W-1:0]   ovr_cnt;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         ovr_cnt   <= '0;
      end else begin
         if (cpu_wait && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (slot_overrun && (ovr_cnt != '1)) begin
            ovr_cnt <= ovr_cnt + 1'b1;
         end
      end
   end

   assign stat_cpu_stall = stall_cnt;
   assign stat_vdg_ovr   = ovr_cnt;
`else
   assign stat_cpu_stall = '0;
   assign stat_vdg_ovr   = '0;
`endif

endmodule
`default_nettype wire
